// File: rtl/cpu_cu_fsm.sv
// Multicycle control unit: fetches instructions over a req/ack RAM port,
// decodes the opcode, sequences the execution unit and owns the PC.
module cpu_cu_fsm #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   input  logic        zero_i,
   input  logic [31:0] se_imm_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        addr_sel_o,
   output logic [31:0] pc_o,
   output logic [25:0] instruction_o,
   output logic [31:0] mdr_o,
   output logic        reg_dst_o,
   output logic        alu_src_o,
   output logic        reg_write_o,
   output logic        mem_to_reg_o,
   output logic [1:0]  alu_op_o,
   output logic [2:0]  state_o,
   output logic [1:0]  err_code_o
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd6
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [1:0] ErrNone    = 2'd0;
   localparam logic [1:0] ErrIllegal = 2'd1;
   localparam logic [1:0] ErrTimeout = 2'd2;

   localparam logic       TimeoutEn  = (TIMEOUT != 0);
   localparam logic [7:0] TimeoutLast = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic [1:0]  err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic        addr_sel_q, addr_sel_d;
   logic        reg_dst_q, reg_dst_d;
   logic        alu_src_q, alu_src_d;
   logic        reg_write_q, reg_write_d;
   logic        mem_to_reg_q, mem_to_reg_d;
   logic [1:0]  alu_op_q, alu_op_d;

   logic [5:0]  op_q, op_d;
   logic        timeout_hit;

   assign op_q = ir_q[31:26];
   assign op_d = ir_d[31:26];
   // The cycle in which the count reaches TIMEOUT; an ack in this cycle still wins.
   assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

   // Next-state, PC/IR/MDR and error logic.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;
      err_d   = err_q;
      cnt_d   = cnt_q + 8'd1;
      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            if (mem_ack_i) begin
               ir_d    = mem_rdata_i;
               pc_d    = pc_q + 32'd4;
               state_d = StDecode;
            end else if (timeout_hit) begin
               err_d   = ErrTimeout;
               state_d = StTrap;
            end
         end
         StDecode: begin
            case (op_q)
               OpRtype, OpLw, OpSw, OpBeq, OpAddi: state_d = StExec;
               OpJ: begin
                  pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                  state_d = StFetch;
               end
               default: begin
                  err_d   = ErrIllegal;
                  state_d = StTrap;
               end
            endcase
         end
         StExec: begin
            case (op_q)
               OpRtype, OpAddi: state_d = StWb;
               OpLw, OpSw:      state_d = StMem;
               default: begin
                  // PC already points past the branch.
                  if (op_q == OpBeq && zero_i) pc_d = pc_q + (se_imm_i << 2);
                  state_d = StFetch;
               end
            endcase
         end
         StMem: begin
            if (mem_ack_i) begin
               if (op_q == OpLw) begin
                  mdr_d   = mem_rdata_i;
                  state_d = StWb;
               end else begin
                  state_d = StFetch;
               end
            end else if (timeout_hit) begin
               err_d   = ErrTimeout;
               state_d = StTrap;
            end
         end
         StWb:    state_d = StFetch;
         StTrap:  state_d = StTrap;
         default: state_d = StTrap;
      endcase
      // Wait counter restarts on every entry into a request state.
      if (state_d != state_q) cnt_d = 8'd0;
   end

   // Registered outputs are decoded from the state being entered.
   always_comb begin
      mem_req_d    = (state_d == StFetch) || (state_d == StMem);
      addr_sel_d   = (state_d == StMem);
      mem_we_d     = (state_d == StMem) && (op_d == OpSw);
      reg_write_d  = (state_d == StWb);
      reg_dst_d    = 1'b0;
      alu_src_d    = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_op_d     = 2'b00;
      if (state_d == StDecode || state_d == StExec || state_d == StMem || state_d == StWb) begin
         case (op_d)
            OpRtype: begin
               reg_dst_d = 1'b1;
               alu_op_d  = 2'b10;
            end
            OpLw: begin
               alu_src_d    = 1'b1;
               mem_to_reg_d = 1'b1;
            end
            OpSw, OpAddi: alu_src_d = 1'b1;
            OpBeq:        alu_op_d  = 2'b01;
            default:      ;
         endcase
      end
   end

   // All state and output registers; reset drops the request asynchronously.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         ir_q         <= 32'd0;
         mdr_q        <= 32'd0;
         err_q        <= ErrNone;
         cnt_q        <= 8'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         addr_sel_q   <= 1'b0;
         reg_dst_q    <= 1'b0;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_op_q     <= 2'b00;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         mdr_q        <= mdr_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         addr_sel_q   <= addr_sel_d;
         reg_dst_q    <= reg_dst_d;
         alu_src_q    <= alu_src_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         alu_op_q     <= alu_op_d;
      end
   end

   assign mem_req_o     = mem_req_q;
   assign mem_we_o      = mem_we_q;
   assign addr_sel_o    = addr_sel_q;
   assign pc_o          = pc_q;
   assign instruction_o = ir_q[25:0];
   assign mdr_o         = mdr_q;
   assign reg_dst_o     = reg_dst_q;
   assign alu_src_o     = alu_src_q;
   assign reg_write_o   = reg_write_q;
   assign mem_to_reg_o  = mem_to_reg_q;
   assign alu_op_o      = alu_op_q;
   assign state_o       = state_q;
   assign err_code_o    = err_q;

endmodule
